sa_inst_sequencer: RTL and testbench

Hardware loop engine that feeds the systolic-array top (init_inst_pulse / instruction / idle_flag / flag interface) without per-instruction host intervention. The host loads one descriptor (opcode, two base addresses, two signed strides, count) and pulses start. The block then issues `count` instructions back-to-back, completing the full handshake for each one. It sits between the host register file and the array top, and replaces testbench-style "pulse, wait negedge idle_flag, wait flag" loops.

---
 rtl/sa_inst_sequencer_pkg.sv | 30 +++
 rtl/sa_seq_addr_gen.sv | 45 ++++
 rtl/sa_inst_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_sa_inst_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_inst_sequencer_pkg.sv
// sa_inst_sequencer_pkg: shared instruction format for the systolic-array front end.
// Holds default field widths, the {opcode, addra, addrb} bit positions (MSB first)
// and the opcode constants used by everything that talks to the array top.
package sa_inst_sequencer_pkg;

  localparam int SA_OPCODE_BITS    = 4;
  localparam int SA_ADDR_BITS      = 32;
  localparam int SA_COUNT_BITS     = 16;
  localparam int SA_TIMEOUT_CYCLES = 65535;
  localparam int SA_INST_BITS      = SA_OPCODE_BITS + 2 * SA_ADDR_BITS;

  // Field positions inside an instruction word.
  localparam int OPCODE_FROM = SA_INST_BITS - 1;
  localparam int OPCODE_TO   = 2 * SA_ADDR_BITS;
  localparam int ADDRA_FROM  = 2 * SA_ADDR_BITS - 1;
  localparam int ADDRA_TO    = SA_ADDR_BITS;
  localparam int ADDRB_FROM  = SA_ADDR_BITS - 1;
  localparam int ADDRB_TO    = 0;

  typedef enum logic [SA_OPCODE_BITS-1:0] {
    NOP_INST               = 4'h0,
    AXI_TO_UB_INST         = 4'h1,
    UB_TO_AXI_INST         = 4'h2,
    MAT_MUL_INST           = 4'h3,
    UB_TO_WEIGHT_FIFO_INST = 4'h4,
    UB_TO_INPUT_FIFO_INST  = 4'h5,
    ACC_TO_UB_INST         = 4'h6
  } sa_opcode_e;

endpackage

// File: rtl/sa_seq_addr_gen.sv
// sa_seq_addr_gen: ADDRA/ADDRB generator for the instruction sequencer.
// Latency: load/step take effect on the next clock edge; outputs are registers.
// Backpressure: none; the caller decides when to step.
// Ports: clk, reset (async, active-high); load captures bases and strides;
//        step adds the signed strides (wrapping modulo 2^ADDR_BITS); addra/addrb current.
module sa_seq_addr_gen
  import sa_inst_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = SA_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [ADDR_BITS-1:0] addra_base,
  input  logic [ADDR_BITS-1:0] addra_stride,
  input  logic [ADDR_BITS-1:0] addrb_base,
  input  logic [ADDR_BITS-1:0] addrb_stride,
  output logic [ADDR_BITS-1:0] addra,
  output logic [ADDR_BITS-1:0] addrb
);

  logic [ADDR_BITS-1:0] stride_a_q;
  logic [ADDR_BITS-1:0] stride_b_q;

  // Strides are two's complement; an unsigned add of the same width gives
  // the signed step with natural wrap-around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addra      <= '0;
      addrb      <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
    end else if (load) begin
      addra      <= addra_base;
      addrb      <= addrb_base;
      stride_a_q <= addra_stride;
      stride_b_q <= addrb_stride;
    end else if (step) begin
      addra <= addra + stride_a_q;
      addrb <= addrb + stride_b_q;
    end
  end

endmodule

// File: rtl/sa_inst_sequencer.sv
// sa_inst_sequencer: hardware loop issuing `count` strided instructions to the systolic array.
// Latency: start -> first init_inst_pulse 2 cycles (array idle); 3 cycles per iteration outside the array.
// Backpressure: each issue waits for idle_flag=1, holds the request until idle_flag=0, then waits for flag.
// Ports: clk/reset (async, active-high); start/abort pulses; cfg_* descriptor captured on start;
//        init_inst_pulse/instruction out to the array, idle_flag/flag back from it;
//        busy, done (1-cycle pulse), aborted (sticky until next start), issued (completed count).
// Build option: define SEQ_TIMEOUT_EN for a per-instruction watchdog of TIMEOUT_CYCLES.
module sa_inst_sequencer
  import sa_inst_sequencer_pkg::*;
#(
  parameter int OPCODE_BITS    = SA_OPCODE_BITS,
  parameter int ADDR_BITS      = SA_ADDR_BITS,
  parameter int COUNT_BITS     = SA_COUNT_BITS,
  parameter int TIMEOUT_CYCLES = SA_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [OPCODE_BITS-1:0]           cfg_opcode,
  input  logic [ADDR_BITS-1:0]             cfg_addra_base,
  input  logic [ADDR_BITS-1:0]             cfg_addra_stride,
  input  logic [ADDR_BITS-1:0]             cfg_addrb_base,
  input  logic [ADDR_BITS-1:0]             cfg_addrb_stride,
  input  logic [COUNT_BITS-1:0]            cfg_count,
  output logic                             init_inst_pulse,
  output logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
  input  logic                             idle_flag,
  input  logic                             flag,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic [COUNT_BITS-1:0]            issued
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sa_inst_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [OPCODE_BITS-1:0] op_q;
  logic [COUNT_BITS-1:0]  count_q;
  logic [COUNT_BITS-1:0]  issued_inc;
  logic                   abort_q;
  logic                   abort_seen;
  logic                   last_iter;
  logic [ADDR_BITS-1:0]   addra;
  logic [ADDR_BITS-1:0]   addrb;

  // Control strobes from the next-state logic.
  logic load_desc;
  logic do_issue;
  logic drop_pulse;
  logic step_addr;
  logic end_by_abort;
  logic wd_hit;

  assign issued_inc = issued + COUNT_BITS'(1);
  assign last_iter  = (issued_inc == count_q);
  // An abort arriving in the deciding cycle counts the same as one latched earlier.
  assign abort_seen = abort_q | abort;

  sa_seq_addr_gen #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load         (load_desc),
    .step         (step_addr),
    .addra_base   (cfg_addra_base),
    .addra_stride (cfg_addra_stride),
    .addrb_base   (cfg_addrb_base),
    .addrb_stride (cfg_addrb_stride),
    .addra        (addra),
    .addrb        (addrb)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_BITS-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == WD_BITS'(TIMEOUT_CYCLES)) &&
                  (state_q == S_WAIT_ACCEPT || state_q == S_WAIT_DONE);

  // Reloads whenever a new request goes out, counts while waiting on the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (do_issue) begin
      wd_cnt <= '0;
    end else if ((state_q == S_WAIT_ACCEPT || state_q == S_WAIT_DONE) && !wd_hit) begin
      wd_cnt <= wd_cnt + WD_BITS'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    load_desc    = 1'b0;
    do_issue     = 1'b0;
    drop_pulse   = 1'b0;
    step_addr    = 1'b0;
    end_by_abort = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_desc = 1'b1;
          state_d   = (cfg_count == '0) ? S_FINISH : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // Waiting for idle_flag also keeps a stale done flag from being mistaken
        // for completion of the next instruction.
        if (abort_seen) begin
          end_by_abort = 1'b1;
          state_d      = S_FINISH;
        end else if (idle_flag) begin
          // Request is registered on the way into ISSUE so it is visible
          // in the ISSUE cycle itself.
          do_issue = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (!idle_flag) begin
          drop_pulse = 1'b1;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (flag) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        step_addr = 1'b1;
        if (last_iter) begin
          state_d = S_FINISH;
        end else if (abort_seen) begin
          end_by_abort = 1'b1;
          state_d      = S_FINISH;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog overrides the wait states; the stuck instruction is not counted.
    if (wd_hit) begin
      drop_pulse   = 1'b1;
      end_by_abort = 1'b1;
      state_d      = S_FINISH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      op_q            <= '0;
      count_q         <= '0;
      abort_q         <= 1'b0;
      init_inst_pulse <= 1'b0;
      instruction     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      issued          <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_FINISH);

      if (load_desc) begin
        op_q    <= cfg_opcode;
        count_q <= cfg_count;
        abort_q <= 1'b0;
        aborted <= 1'b0;
        issued  <= '0;
        busy    <= 1'b1;
      end else if (state_q != S_IDLE && abort) begin
        abort_q <= 1'b1;
      end

      if (state_q == S_FINISH) begin
        busy <= 1'b0;
      end

      if (do_issue) begin
        instruction     <= {op_q, addra, addrb};
        init_inst_pulse <= 1'b1;
      end else if (drop_pulse) begin
        init_inst_pulse <= 1'b0;
      end

      if (step_addr) begin
        issued <= issued_inc;
      end

      if (end_by_abort) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// tb_sa_inst_sequencer: self-checking bench for sa_inst_sequencer with a behavioural array model.
// Latency: n/a (testbench).
// Backpressure: the array model controls accept/done delays and can hold idle_flag low.
module tb_sa_inst_sequencer;
  import sa_inst_sequencer_pkg::*;

  localparam int OB = SA_OPCODE_BITS;
  localparam int AB = SA_ADDR_BITS;
  localparam int CB = SA_COUNT_BITS;
  localparam int IB = SA_INST_BITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [OB-1:0] cfg_opcode;
  logic [AB-1:0] cfg_addra_base, cfg_addra_stride, cfg_addrb_base, cfg_addrb_stride;
  logic [CB-1:0] cfg_count;
  logic          init_inst_pulse;
  logic [IB-1:0] instruction;
  logic          idle_flag;
  logic          flag;
  logic          busy, done, aborted;
  logic [CB-1:0] issued;

  sa_inst_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .cfg_opcode       (cfg_opcode),
    .cfg_addra_base   (cfg_addra_base),
    .cfg_addra_stride (cfg_addra_stride),
    .cfg_addrb_base   (cfg_addrb_base),
    .cfg_addrb_stride (cfg_addrb_stride),
    .cfg_count        (cfg_count),
    .init_inst_pulse  (init_inst_pulse),
    .instruction      (instruction),
    .idle_flag        (idle_flag),
    .flag             (flag),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .issued           (issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Descriptor of the loop in flight, as the reference model sees it.
  logic [OB-1:0] e_op;
  logic [AB-1:0] e_ba, e_sa, e_bb, e_sb;

  // Instruction k of a loop is base + k*stride for each address, modulo 2^32.
  function automatic logic [IB-1:0] exp_inst(input int k);
    logic [IB-1:0] r;
    logic [AB-1:0] kk;
    kk = AB'(k);
    r = '0;
    r[OPCODE_FROM:OPCODE_TO] = e_op;
    r[ADDRA_FROM:ADDRA_TO]   = e_ba + kk * e_sa;
    r[ADDRB_FROM:ADDRB_TO]   = e_bb + kk * e_sb;
    return r;
  endfunction

  // ---------------- monitor: pulse rises and done cycles ----------------
  int   pulse_n = 0;
  int   done_n  = 0;
  int   done_cyc_last = 0;
  int   rise_cyc[$];
  logic prev_pulse = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (init_inst_pulse && !prev_pulse) begin
        pulse_n++;
        rise_cyc.push_back(cyc);
      end
      prev_pulse = init_inst_pulse;
      if (done) begin
        done_n++;
        done_cyc_last = cyc;
      end
    end
  end

  // ---------------- behavioural array model ----------------
  int acc_n = 0;
  int acc_base = 0;
  int acc_lat = 3;
  int done_lat = 20;
  bit hold_flag = 1'b0;
  bit force_busy = 1'b0;

  initial begin
    int ast;
    int acnt;
    int k;
    bit just_acc;
    ast = 0; acnt = 0; just_acc = 1'b0;
    idle_flag = 1'b1;
    flag = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ast = 0; just_acc = 1'b0;
        idle_flag = 1'b1;
        flag = 1'b0;
      end else begin
        if (just_acc) begin
          chk("pulse_dropped_after_accept", 128'(init_inst_pulse), 128'(0));
          just_acc = 1'b0;
        end
        case (ast)
          0: begin
            idle_flag = !force_busy;
            if (!hold_flag) flag = 1'b0;
            if (init_inst_pulse) begin
              ast = 1;
              acnt = acc_lat;
            end
          end
          1: begin
            acnt--;
            if (acnt == 0) begin
              k = acc_n - acc_base;
              chk("instruction_at_accept", 128'(instruction), 128'(exp_inst(k)));
              chk("issued_at_accept", 128'(issued), 128'(k));
              chk("pulse_held_until_accept", 128'(init_inst_pulse), 128'(1));
              acc_n++;
              idle_flag = 1'b0;
              flag = 1'b0;
              ast = 2;
              acnt = done_lat;
              just_acc = 1'b1;
            end
          end
          default: begin
            acnt--;
            if (acnt == 0) begin
              flag = 1'b1;
              idle_flag = 1'b1;
              ast = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  int pulse_b, done_b, start_cyc;

  task automatic launch(input logic [OB-1:0] op, input logic [AB-1:0] ba, input logic [AB-1:0] sa,
                        input logic [AB-1:0] bb, input logic [AB-1:0] sb, input int cnt,
                        input bit with_abort);
    @(negedge clk);
    e_op = op; e_ba = ba; e_sa = sa; e_bb = bb; e_sb = sb;
    cfg_opcode = op; cfg_addra_base = ba; cfg_addra_stride = sa;
    cfg_addrb_base = bb; cfg_addrb_stride = sb; cfg_count = CB'(cnt);
    acc_base = acc_n; pulse_b = pulse_n; done_b = done_n; start_cyc = cyc;
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_n == done_b && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done_n == done_b) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=no done expected=done within 20000 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_acc(input int n, input string name);
    int c;
    c = 0;
    while (acc_n - acc_base < n && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (acc_n - acc_base < n) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout actual=%0d expected=%0d accepts", name, acc_n - acc_base, n);
    end
  endtask

  task automatic check_end(input string name, input int exp_issued, input bit exp_aborted);
    chk({name, "_issued"}, 128'(issued), 128'(exp_issued));
    chk({name, "_aborted"}, 128'(aborted), 128'(exp_aborted));
    chk({name, "_busy_low"}, 128'(busy), 128'(0));
    chk({name, "_single_done"}, 128'(done_n - done_b), 128'(1));
    chk({name, "_pulses"}, 128'(pulse_n - pulse_b), 128'(exp_issued));
    chk({name, "_accepts"}, 128'(acc_n - acc_base), 128'(exp_issued));
  endtask

  task automatic check_latency(input string name, input int cnt);
    if (cnt == 0) chk({name, "_zero_done_latency"}, 128'(done_cyc_last - start_cyc), 128'(2));
    else          chk({name, "_first_pulse_latency"}, 128'(rise_cyc[pulse_b] - start_cyc), 128'(2));
  endtask

  // ---------------- table of directed loops ----------------
  typedef struct {
    logic [OB-1:0] op;
    logic [AB-1:0] ba, sa, bb, sb;
    int            cnt, acc, dl;
    bit            hold;
    logic [AB-1:0] last_a, last_b;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [IB-1:0] last_exp;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_opcode = '0; cfg_addra_base = '0; cfg_addra_stride = '0;
    cfg_addrb_base = '0; cfg_addrb_stride = '0; cfg_count = '0;
    e_op = '0; e_ba = '0; e_sa = '0; e_bb = '0; e_sb = '0;

    // UB fill, reverse stride, wrap with stale flag held high, zero count.
    tbl[0] = '{AXI_TO_UB_INST, 32'd0, 32'd1, 32'd0, 32'd16, 256, 3, 20, 1'b0, 32'd255, 32'd4080};
    tbl[1] = '{MAT_MUL_INST, 32'd0, 32'd1, 32'd4080, 32'hFFFF_FFF0, 4, 2, 5, 1'b0, 32'd3, 32'd4032};
    tbl[2] = '{UB_TO_AXI_INST, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd7, 2, 3, 4, 1'b1, 32'd0, 32'd12};
    tbl[3] = '{MAT_MUL_INST, 32'd7, 32'd9, 32'd11, 32'd13, 0, 1, 1, 1'b0, 32'd0, 32'd0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({init_inst_pulse, instruction, busy, done, aborted, issued}), 128'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_outputs", 128'({init_inst_pulse, instruction, busy, done, aborted, issued}), 128'(0));

    for (int i = 0; i < 4; i++) begin
      acc_lat = tbl[i].acc; done_lat = tbl[i].dl; hold_flag = tbl[i].hold;
      launch(tbl[i].op, tbl[i].ba, tbl[i].sa, tbl[i].bb, tbl[i].sb, tbl[i].cnt, 1'b0);
      wait_done($sformatf("vec%0d", i));
      check_end($sformatf("vec%0d", i), tbl[i].cnt, 1'b0);
      check_latency($sformatf("vec%0d", i), tbl[i].cnt);
      if (tbl[i].cnt > 0) begin
        last_exp = {tbl[i].op, tbl[i].last_a, tbl[i].last_b};
        chk($sformatf("vec%0d_last_instruction", i), 128'(instruction), 128'(last_exp));
      end
    end
    hold_flag = 1'b0;

    // Abort during the 5th instruction's wait for done.
    acc_lat = 3; done_lat = 20;
    launch(AXI_TO_UB_INST, 32'd0, 32'd1, 32'd0, 32'd16, 16, 1'b0);
    wait_acc(5, "abort_mid");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_mid");
    check_end("abort_mid", 5, 1'b1);

    // Abort while stuck in WAIT_IDLE before anything is issued.
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    launch(MAT_MUL_INST, 32'd1, 32'd1, 32'd2, 32'd2, 4, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_before_issue");
    check_end("abort_before_issue", 0, 1'b1);
    force_busy = 1'b0;

    // start and abort together from IDLE: start wins, sticky aborted is cleared.
    acc_lat = 1; done_lat = 2;
    launch(UB_TO_AXI_INST, 32'd10, 32'd3, 32'd20, 32'd5, 3, 1'b1);
    wait_done("start_and_abort");
    check_end("start_and_abort", 3, 1'b0);

    // A second start with a different descriptor while busy is ignored.
    acc_lat = 2; done_lat = 6;
    launch(AXI_TO_UB_INST, 32'd100, 32'd4, 32'd200, 32'd8, 3, 1'b0);
    wait_acc(1, "start_while_busy");
    @(negedge clk);
    cfg_opcode = MAT_MUL_INST; cfg_addra_base = 32'd999; cfg_addra_stride = 32'd77;
    cfg_addrb_base = 32'd555; cfg_addrb_stride = 32'd33; cfg_count = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_while_busy");
    check_end("start_while_busy", 3, 1'b0);
    last_exp = {AXI_TO_UB_INST, 32'd108, 32'd216};
    chk("start_while_busy_last_instruction", 128'(instruction), 128'(last_exp));

    // Reset in the middle of WAIT_DONE clears every output immediately.
    acc_lat = 2; done_lat = 30;
    launch(MAT_MUL_INST, 32'd40, 32'd2, 32'd50, 32'd4, 4, 1'b0);
    wait_acc(2, "reset_mid");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_pulse", 128'(init_inst_pulse), 128'(0));
    chk("reset_mid_instruction", 128'(instruction), 128'(0));
    chk("reset_mid_busy", 128'(busy), 128'(0));
    chk("reset_mid_issued", 128'(issued), 128'(0));
    chk("reset_mid_done_aborted", 128'({done, aborted}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mid_stays_idle", 128'({busy, init_inst_pulse}), 128'(0));

    // Randomised descriptors and array timing against the reference model.
    for (int r = 0; r < 10; r++) begin
      int cnt;
      cnt = int'($urandom_range(0, 6));
      acc_lat = int'($urandom_range(1, 4));
      done_lat = int'($urandom_range(1, 6));
      hold_flag = 1'($urandom_range(0, 1));
      launch(OB'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom, cnt, 1'b0);
      wait_done($sformatf("rand%0d", r));
      check_end($sformatf("rand%0d", r), cnt, 1'b0);
      check_latency($sformatf("rand%0d", r), cnt);
      if (cnt > 0) chk($sformatf("rand%0d_last_instruction", r), 128'(instruction), 128'(exp_inst(cnt - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL global_timeout actual=still running expected=finished within 80000 cycles");
    $fatal(1, "global timeout");
  end

endmodule
